draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NCLIENTS, default 4, meaning number of drawing clients served.
REQ-002 SHALL have parameter CNTW, default 34, meaning pixel-counter width, sized to hold 65536*65536.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port update  input  NCLIENTS  per-client redraw request.
REQ-006 SHALL have port draw  output  NCLIENTS  one-hot grant; holding a client in draw mode.
REQ-007 SHALL have port cnext  output  NCLIENTS  one-cycle pulse; advances the granted client to its next pixel.
REQ-008 SHALL have port drawdone  input  NCLIENTS  per-client idle/finished flag.
REQ-009 SHALL have ports xstart, xend, ystart, yend, color  input  16*NCLIENTS each  per-client window and current pixel colour, packed with client i at bits [16i +: 16].
REQ-010 SHALL have port win_valid / win_ready  output / input  1 each  window-command handshake to the LCD controller.
REQ-011 SHALL have ports win_x0, win_x1, win_y0, win_y1  output  16 each  latched window of the granted client.
REQ-012 SHALL have port pix_valid / pix_ready  output / input  1 each  pixel-stream handshake.
REQ-013 SHALL have port pix_data  output  16  RGB565 value; combinational mux of the granted client's color.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, GRANT, WIN, STREAM and FINISH.
REQ-016 IDLE: when any update bit is high and that client's drawdone is high, SHALL select one client (REQ-030), set draw[sel]=1, and go to GRANT.
REQ-017 GRANT, one cycle: SHALL latch the window and count = (xend-xstart+1)*(yend-ystart+1), computed unsigned in 17x17 bits, then go to WIN; drawdone SHALL be ignored in this cycle.
REQ-018 WIN: win_valid=1; on win_valid&&win_ready SHALL go to STREAM.
REQ-019 STREAM: pix_valid=1; each cycle with pix_valid&&pix_ready SHALL pulse cnext[sel] in that same cycle and decrement count.
REQ-020 On acceptance of the last pixel (count==1), draw[sel] SHALL fall on that same clock edge and the state SHALL go to FINISH; no further cnext.
REQ-021 FINISH: SHALL wait for drawdone[sel]==1, then go to IDLE; earliest re-grant is the cycle after.
REQ-022 pix_ready low SHALL stall: no cnext, count held, pix_data tracks the client's color.
REQ-023 xend<xstart or yend<ystart SHALL be treated as modulo-2^16 wrap; no error detection.
REQ-024 update changes in non-IDLE states SHALL be ignored until IDLE.
REQ-025 cnext and draw SHALL be zero for all non-selected clients at all times.

Reset
REQ-026 On rst: state=IDLE, draw=0, cnext=0, win_valid=0, pix_valid=0, busy=0, count=0, rr pointer=0.
REQ-027 rst mid-STREAM SHALL abort: draw drops on the next edge; the partial frame is not resumed.

Configuration
REQ-028 Macro DRAW_SEQ_ROUNDROBIN_EN defined: SHALL use round-robin arbitration; search starts at (last granted + 1) mod NCLIENTS.
REQ-029 Macro DRAW_SEQ_ROUNDROBIN_EN undefined: SHALL use fixed priority, lowest index wins; no pointer register.
REQ-030 Arbitration SHALL consider only clients with update&&drawdone.

Structure
REQ-031 Package draw_pkg SHALL hold the state enum, the 16-bit coordinate/colour typedefs and CNTW.
REQ-032 Arbitration SHALL be a sub-module draw_arb (request vector, pointer -> one-hot grant).

Verification
REQ-033 NCLIENTS=4, update[2]=1, window 10..12 x 5..6 (count 6), ready always high -> win at 10/12/5/6, exactly 6 cnext[2] pulses, draw[2] low the edge after the 6th.
REQ-034 Same test with pix_ready toggling 1/0 -> 6 pixels in 12 cycles, cnext only on accepted beats.
REQ-035 update=4'b1011 with ROUNDROBIN_EN, last grant 1 -> grant order 3, 0, 1; without the macro -> grant order 0, 1, 3.
REQ-036 rst asserted at the 3rd pixel -> next cycle all outputs at reset values, busy=0.
REQ-037 win_ready held low for 5 cycles -> win_valid held, no pix_valid, no cnext.
REQ-038 1x1 window -> one pixel and one cnext; FINISH waits for drawdone, which is delayed 3 cycles, before re-grant.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types for the draw sequencer: FSM states, 16-bit coordinate/colour
// types and the default pixel-counter width.
package draw_pkg;

  localparam int unsigned CNTW = 34;

  typedef logic [15:0] coord_t;
  typedef logic [15:0] color_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    WIN    = 3'd2,
    STREAM = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Window pixel count; reversed bounds wrap modulo 2^16.
  function automatic logic [33:0] win_area(coord_t x0, coord_t x1, coord_t y0, coord_t y1);
    coord_t      dx;
    coord_t      dy;
    logic [16:0] w;
    logic [16:0] h;
    dx = x1 - x0;
    dy = y1 - y0;
    w  = {1'b0, dx} + 17'd1;
    h  = {1'b0, dy} + 17'd1;
    return w * h;
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Window-command and pixel-stream handshake between the sequencer and the LCD controller.
interface draw_sequencer_if;
  import draw_pkg::*;

  logic   win_valid;
  logic   win_ready;
  coord_t win_x0;
  coord_t win_x1;
  coord_t win_y0;
  coord_t win_y1;
  logic   pix_valid;
  logic   pix_ready;
  color_t pix_data;

  modport master (
    output win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
    input  win_ready, pix_ready
  );

  modport slave (
    input  win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
    output win_ready, pix_ready
  );
endinterface

// File: rtl/draw_arb.sv
// Rotating-priority arbiter: first requester at or after ptr wins (ptr=0 gives
// plain lowest-index priority).
module draw_arb #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned PW       = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1
) (
  input  logic [NCLIENTS-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [NCLIENTS-1:0] grant
);

  always_comb begin
    logic [PW:0] pos;
    logic        found;
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NCLIENTS; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NCLIENTS)) pos = pos - (PW+1)'(NCLIENTS);
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Grants one drawing client at a time, sends its window to the LCD and streams
// its pixels. Define DRAW_SEQ_ROUNDROBIN_EN for round-robin arbitration.
module draw_sequencer #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned CNTW     = draw_pkg::CNTW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCLIENTS-1:0]    update,
  output logic [NCLIENTS-1:0]    draw,
  output logic [NCLIENTS-1:0]    cnext,
  input  logic [NCLIENTS-1:0]    drawdone,
  input  logic [16*NCLIENTS-1:0] xstart,
  input  logic [16*NCLIENTS-1:0] xend,
  input  logic [16*NCLIENTS-1:0] ystart,
  input  logic [16*NCLIENTS-1:0] yend,
  input  logic [16*NCLIENTS-1:0] color,
  draw_sequencer_if.master       lcd,
  output logic                   busy
);
  import draw_pkg::*;

  localparam int unsigned PW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  state_t              state;
  logic [NCLIENTS-1:0] sel_oh;
  logic [NCLIENTS-1:0] draw_q;
  logic [NCLIENTS-1:0] req;
  logic [NCLIENTS-1:0] grant;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       ptr;
  logic [CNTW-1:0]     count;
  coord_t              wx0, wx1, wy0, wy1;
  coord_t              xs, xe, ys, ye;
  color_t              cc;
  logic                accept;

  assign req = update & drawdone;

`ifdef DRAW_SEQ_ROUNDROBIN_EN
  logic [PW-1:0] rr_ptr;
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == IDLE && |req)
      rr_ptr <= (gidx == PW'(NCLIENTS-1)) ? '0 : gidx + 1'b1;
  end
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  draw_arb #(.NCLIENTS(NCLIENTS), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned k = 0; k < NCLIENTS; k++)
      if (grant[k]) gidx = PW'(k);
  end

  always_comb begin
    xs = '0;
    xe = '0;
    ys = '0;
    ye = '0;
    cc = '0;
    for (int unsigned k = 0; k < NCLIENTS; k++) begin
      if (sel == PW'(k)) begin
        xs = xstart[16*k +: 16];
        xe = xend[16*k +: 16];
        ys = ystart[16*k +: 16];
        ye = yend[16*k +: 16];
        cc = color[16*k +: 16];
      end
    end
  end

  assign accept = (state == STREAM) && lcd.pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_oh <= '0;
      sel    <= '0;
      draw_q <= '0;
      count  <= '0;
      wx0    <= '0;
      wx1    <= '0;
      wy0    <= '0;
      wy1    <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          sel_oh <= grant;
          sel    <= gidx;
          draw_q <= grant;
          state  <= GRANT;
        end
        GRANT: begin
          wx0   <= xs;
          wx1   <= xe;
          wy0   <= ys;
          wy1   <= ye;
          count <= CNTW'(win_area(xs, xe, ys, ye));
          state <= WIN;
        end
        WIN: if (lcd.win_ready) state <= STREAM;
        // draw drops on the edge that accepts the last pixel
        STREAM: if (lcd.pix_ready) begin
          count <= count - CNTW'(1);
          if (count == CNTW'(1)) begin
            draw_q <= '0;
            state  <= FINISH;
          end
        end
        FINISH: if (|(drawdone & sel_oh)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign draw          = draw_q;
  assign cnext         = accept ? sel_oh : '0;
  assign busy          = (state != IDLE);
  assign lcd.win_valid = (state == WIN);
  assign lcd.pix_valid = (state == STREAM);
  assign lcd.pix_data  = cc;
  assign lcd.win_x0    = wx0;
  assign lcd.win_x1    = wx1;
  assign lcd.win_y0    = wy0;
  assign lcd.win_y1    = wy1;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a pixel/window scoreboard.
module tb_draw_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  update   = '0;
  logic [3:0]  drawdone = '1;
  logic [3:0]  draw;
  logic [3:0]  cnext;
  logic [63:0] xstart = '0;
  logic [63:0] xend   = '0;
  logic [63:0] ystart = '0;
  logic [63:0] yend   = '0;
  logic [63:0] color;
  logic        busy;

  draw_sequencer_if lcd ();

  draw_sequencer #(.NCLIENTS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .draw     (draw),
    .cnext    (cnext),
    .drawdone (drawdone),
    .xstart   (xstart),
    .xend     (xend),
    .ystart   (ystart),
    .yend     (yend),
    .color    (color),
    .lcd      (lcd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Client model: each client's colour steps by one on every cnext it receives.
  logic [15:0] pixcnt [4] = '{default: '0};
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (cnext[i]) pixcnt[i] <= pixcnt[i] + 16'd1;

  always_comb begin
    color = '0;
    for (int i = 0; i < 4; i++)
      color[16*i +: 16] = (16'(i) << 12) ^ pixcnt[i];
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cn_cnt [4] = '{default: 0};

  typedef struct packed { logic [15:0] color; logic [3:0] mask; } pix_t;
  typedef struct packed { logic [63:0] win;   logic [3:0] mask; } win_t;
  pix_t pq [$];
  win_t wq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : mon
    pix_t e;
    win_t w;
    if (lcd.pix_valid && lcd.pix_ready) begin
      if (pq.size() == 0) check("pix_unexpected_qsize", 64'(pq.size()), 64'd1);
      else begin
        e = pq.pop_front();
        check("pix_data", 64'(lcd.pix_data), 64'(e.color));
        check("cnext_beat", 64'(cnext), 64'(e.mask));
      end
    end else check("cnext_idle", 64'(cnext), 64'd0);
    if (lcd.win_valid && lcd.win_ready) begin
      if (wq.size() == 0) check("win_unexpected_qsize", 64'(wq.size()), 64'd1);
      else begin
        w = wq.pop_front();
        check("win_coords", {lcd.win_x0, lcd.win_x1, lcd.win_y0, lcd.win_y1}, w.win);
        check("win_draw", 64'(draw), 64'(w.mask));
      end
    end
    for (int i = 0; i < 4; i++) cn_cnt[i] += int'(cnext[i]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prepare(input int c, input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1, output int n);
    logic [15:0] dx, dy;
    logic [16:0] w, h;
    pix_t        p;
    win_t        wv;
    xstart[16*c +: 16] = x0;
    xend[16*c +: 16]   = x1;
    ystart[16*c +: 16] = y0;
    yend[16*c +: 16]   = y1;
    dx = x1 - x0;
    dy = y1 - y0;
    w  = {1'b0, dx} + 17'd1;
    h  = {1'b0, dy} + 17'd1;
    n  = int'(w * h);
    wv.win  = {x0, x1, y0, y1};
    wv.mask = 4'b0001 << c;
    wq.push_back(wv);
    for (int k = 0; k < n; k++) begin
      p.color = (16'(c) << 12) ^ (pixcnt[c] + 16'(k));
      p.mask  = 4'b0001 << c;
      pq.push_back(p);
    end
  endtask

  task automatic serve(input int c, input int n, input bit toggle, input int win_hold,
                       input int abort_at, input int dd, input bit keep, input int exp_cycles);
    int t, rem, scyc, c0;
    logic [3:0] oh;
    oh = 4'b0001 << c;
    c0 = cn_cnt[c];
    t  = 0;
    while (draw == 4'd0 && t < 30) begin step(); t++; end
    check("grant_onehot", 64'(draw), 64'(oh));
    check("grant_busy", 64'(busy), 64'd1);
    if (!keep) update[c] = 1'b0;
    if (dd > 0) drawdone[c] = 1'b0;
    step();
    for (int i = 0; i < win_hold; i++) begin
      lcd.win_ready = 1'b0;
      check("winhold_valid", 64'(lcd.win_valid), 64'd1);
      check("winhold_nopix", 64'(lcd.pix_valid), 64'd0);
      check("winhold_nocnext", 64'(cnext), 64'd0);
      step();
    end
    check("win_valid", 64'(lcd.win_valid), 64'd1);
    lcd.win_ready = 1'b1;
    step();
    lcd.win_ready = 1'b0;
    rem  = n;
    scyc = 0;
    for (t = 0; t < 4*n + 10 && rem > 0; t++) begin
      if (lcd.pix_valid) begin
        lcd.pix_ready = toggle ? scyc[0] : 1'b1;
        scyc++;
      end
      if (lcd.pix_valid && lcd.pix_ready) begin
        rem--;
        if (abort_at > 0 && n - rem == abort_at) begin
          rst = 1'b1;
          step();
          check("abort_draw", 64'(draw), 64'd0);
          check("abort_cnext", 64'(cnext), 64'd0);
          check("abort_winv", 64'(lcd.win_valid), 64'd0);
          check("abort_pixv", 64'(lcd.pix_valid), 64'd0);
          check("abort_busy", 64'(busy), 64'd0);
          check("abort_cnext_cnt", 64'(cn_cnt[c] - c0), 64'(abort_at));
          rst = 1'b0;
          pq.delete();
          wq.delete();
          lcd.pix_ready = 1'b1;
          return;
        end
      end
      step();
    end
    check("pix_remaining", 64'(rem), 64'd0);
    check("stream_cycles", 64'(scyc), 64'(exp_cycles));
    check("finish_draw", 64'(draw), 64'd0);
    check("finish_busy", 64'(busy), 64'd1);
    for (int i = 0; i < dd; i++) begin
      step();
      check("finish_wait_busy", 64'(busy), 64'd1);
      check("finish_wait_draw", 64'(draw), 64'd0);
    end
    drawdone[c] = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_draw", 64'(draw), 64'd0);
    if (keep) begin
      step();
      check("regrant", 64'(draw), 64'(oh));
    end
    check("cnext_count", 64'(cn_cnt[c] - c0), 64'(n));
    lcd.pix_ready = 1'b1;
  endtask

`ifdef DRAW_SEQ_ROUNDROBIN_EN
  int order [3] = '{3, 0, 1};
`else
  int order [3] = '{0, 1, 3};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int na [3];
    lcd.win_ready = 1'b0;
    lcd.pix_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check("rst_draw", 64'(draw), 64'd0);
    check("rst_cnext", 64'(cnext), 64'd0);
    check("rst_winv", 64'(lcd.win_valid), 64'd0);
    check("rst_pixv", 64'(lcd.pix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // 3x2 window on client 2, ready always high
    prepare(2, 16'd10, 16'd12, 16'd5, 16'd6, n);
    check("count_example", 64'(n), 64'd6);
    update[2] = 1'b1;
    serve(2, n, 1'b0, 0, 0, 0, 1'b0, 6);

    // same window, pix_ready alternating
    prepare(2, 16'd10, 16'd12, 16'd5, 16'd6, n);
    update[2] = 1'b1;
    serve(2, n, 1'b1, 0, 0, 0, 1'b0, 12);

    // win_ready held low for 5 cycles; leaves client 1 as last grant
    prepare(1, 16'd0, 16'd1, 16'd0, 16'd0, n);
    update[1] = 1'b1;
    serve(1, n, 1'b0, 5, 0, 0, 1'b0, 2);

    // arbitration among clients 0, 1, 3
    for (int k = 0; k < 3; k++)
      prepare(order[k], 16'(order[k]), 16'(order[k]), 16'd0, 16'd0, na[k]);
    update = 4'b1011;
    for (int k = 0; k < 3; k++)
      serve(order[k], na[k], 1'b0, 0, 0, 0, 1'b0, 1);

    // reversed x bounds wrap: FFFF..0001 is 3 pixels wide
    prepare(3, 16'hFFFF, 16'h0001, 16'd7, 16'd7, n);
    check("count_wrap", 64'(n), 64'd3);
    update[3] = 1'b1;
    serve(3, n, 1'b0, 0, 0, 0, 1'b0, 3);

    // reset at the third pixel of an 8-pixel frame
    prepare(0, 16'd0, 16'd3, 16'd0, 16'd1, n);
    update[0] = 1'b1;
    serve(0, n, 1'b0, 0, 3, 0, 1'b0, 0);
    repeat (2) step();
    check("post_abort_idle", 64'(busy), 64'd0);

    // 1x1 window, drawdone delayed 3 cycles, then re-grant
    prepare(0, 16'd20, 16'd20, 16'd30, 16'd30, n);
    check("count_1x1", 64'(n), 64'd1);
    update[0] = 1'b1;
    serve(0, n, 1'b0, 0, 0, 3, 1'b1, 1);
    prepare(0, 16'd20, 16'd20, 16'd30, 16'd30, n);
    serve(0, n, 1'b0, 0, 0, 0, 1'b0, 1);

    repeat (3) step();
    check("pix_queue_drained", 64'(pq.size()), 64'd0);
    check("win_queue_drained", 64'(wq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
